dsp_mac_sequencer: RTL and testbench

//  Drives one int8 dsp_slice as a streaming dot-product engine: accepts (a,b) operand pairs, issues them to the slice.

---
 rtl/dsp_seq_pkg.sv | 19 +
 rtl/dsp_mac_sequencer_if.sv | 25 ++
 rtl/dsp_result_fifo.sv | 54 +++++
 rtl/dsp_slice.sv | 57 +++++
 rtl/dsp_mac_sequencer.sv | 130 +++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared constants and types for the dot-product sequencer that drives one dsp_slice.
package dsp_seq_pkg;

  localparam int ISSUE_TO_CTRL  = 2;
  localparam int CTRL_TO_RESULT = 1;
  localparam int FLUSH_CYCLES   = 2;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  typedef enum logic {
    FLUSH,
    RUN
  } state_t;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand-in / result-out streaming bus of the dot-product sequencer.
interface dsp_mac_sequencer_if #(
  parameter int DWIDTH = 8,
  parameter int LEN_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_a;
  logic [DWIDTH-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [LEN_W-1:0]  out_len;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_len
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_len
  );
endinterface

// File: rtl/dsp_result_fifo.sv
// First-word-fall-through result FIFO; push and pop may coincide even when full.
module dsp_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] pop_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid    = (count_reg != '0);
  assign do_pop   = pop & valid;
  assign do_push  = push & ((count_reg != CW'(DEPTH)) | do_pop);
  // Head is forced to zero when empty so stale entries never appear on the bus
  assign pop_data = valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dsp_slice.sv
// int8 MAC slice: registered operands, saturating multiply, wrapping accumulator.
module dsp_slice #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] ax,
  input  logic [DWIDTH-1:0] ay,
  input  logic [DWIDTH-1:0] az,
  input  logic              carry_in,
  input  logic              multiply,
  input  logic              accum,
  output logic [DWIDTH-1:0] result,
  output logic              carry_out
);
  localparam int PW = 2 * DWIDTH;

  logic [DWIDTH-1:0]        y_reg, z_reg, acc_reg;
  logic                     cout_reg;
  logic signed [PW-1:0]     prod_full;
  logic [PW-DWIDTH:0]       prod_hi;
  logic [DWIDTH-1:0]        prod_sat;
  logic [DWIDTH:0]          sum;

  assign prod_full = $signed(y_reg) * $signed(z_reg);
  assign prod_hi   = prod_full[PW-1:DWIDTH-1];

  // Product saturates when the sign-extension bits disagree
  always_comb begin
    prod_sat = prod_full[DWIDTH-1:0];
    if (!((&prod_hi) || (~|prod_hi)))
      prod_sat = prod_full[PW-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
  end

  assign sum = {1'b0, acc_reg} + {1'b0, prod_sat} + {{DWIDTH{1'b0}}, carry_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      y_reg    <= '0;
      z_reg    <= '0;
      acc_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      y_reg <= ay;
      z_reg <= az;
      if (multiply)
        acc_reg <= prod_sat;
      else if (accum)
        {cout_reg, acc_reg} <= sum;
      else
        acc_reg <= ax;
    end
  end

  assign result    = acc_reg;
  assign carry_out = cout_reg;
endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams operand pairs into a dsp_slice and collects one wrapping dot product per vector.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  dsp_mac_sequencer_if.slave s,
  output logic              dsp_reset,
  output logic [DWIDTH-1:0] dsp_ax,
  output logic [DWIDTH-1:0] dsp_ay,
  output logic [DWIDTH-1:0] dsp_az,
  output logic              dsp_carry_in,
  output logic              dsp_multiply,
  output logic              dsp_accum,
  input  logic [DWIDTH-1:0] dsp_result
);
  localparam int CR_W = $clog2(FIFO_DEPTH + 1);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t                  state_reg;
  logic [FC_W-1:0]         flush_cnt_reg;
  logic [CR_W-1:0]         credits_reg, credits_next;
  logic                    first_pending_reg;
  logic [LEN_W-1:0]        len_reg, elem_len;
  logic [DWIDTH-1:0]       ay_reg, az_reg;
  tag_t                    tag_pipe     [ISSUE_TO_CTRL];
  logic [LEN_W-1:0]        len_pipe     [ISSUE_TO_CTRL];
  logic                    cap_vld_pipe [CTRL_TO_RESULT];
  logic [LEN_W-1:0]        cap_len_pipe [CTRL_TO_RESULT];
  tag_t                    ctrl_tag;
  logic                    in_ready, accept, pop, fifo_valid;
  logic [DWIDTH+LEN_W-1:0] fifo_data;

  assign in_ready = (state_reg == RUN) && (credits_reg < CR_W'(FIFO_DEPTH));
  assign accept   = s.in_valid & in_ready;
  assign pop      = fifo_valid & s.out_ready;
  assign elem_len = first_pending_reg ? LEN_W'(1) : len_reg + LEN_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= FLUSH;
      flush_cnt_reg <= '0;
    end else if (state_reg == FLUSH) begin
      if (flush_cnt_reg == FC_W'(FLUSH_CYCLES))
        state_reg <= RUN;
      else
        flush_cnt_reg <= flush_cnt_reg + FC_W'(1);
    end
  end

  // Credits reserve a FIFO slot from the moment a last is accepted until it is popped
  always_comb begin
    credits_next = credits_reg;
    case ({accept & s.in_last, pop})
      2'b10:   credits_next = credits_reg + CR_W'(1);
      2'b01:   credits_next = credits_reg - CR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ay_reg            <= '0;
      az_reg            <= '0;
      first_pending_reg <= 1'b1;
      len_reg           <= '0;
      credits_reg       <= '0;
      for (int i = 0; i < ISSUE_TO_CTRL; i++) begin
        tag_pipe[i] <= '0;
        len_pipe[i] <= '0;
      end
      for (int i = 0; i < CTRL_TO_RESULT; i++) begin
        cap_vld_pipe[i] <= 1'b0;
        cap_len_pipe[i] <= '0;
      end
    end else begin
      ay_reg      <= accept ? s.in_a : '0;
      az_reg      <= accept ? s.in_b : '0;
      credits_reg <= credits_next;
      if (accept) begin
        first_pending_reg <= s.in_last;
        len_reg           <= elem_len;
      end
      tag_pipe[0] <= '{vld: accept, first: accept & first_pending_reg, last: accept & s.in_last};
      len_pipe[0] <= elem_len;
      for (int i = 1; i < ISSUE_TO_CTRL; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
        len_pipe[i] <= len_pipe[i-1];
      end
      // One cycle after the final add the slice result holds the finished sum
      cap_vld_pipe[0] <= ctrl_tag.vld & ctrl_tag.last;
      cap_len_pipe[0] <= len_pipe[ISSUE_TO_CTRL-1];
      for (int i = 1; i < CTRL_TO_RESULT; i++) begin
        cap_vld_pipe[i] <= cap_vld_pipe[i-1];
        cap_len_pipe[i] <= cap_len_pipe[i-1];
      end
    end
  end

  assign ctrl_tag     = tag_pipe[ISSUE_TO_CTRL-1];
  assign dsp_reset    = (state_reg == FLUSH);
  assign dsp_ax       = '0;
  assign dsp_ay       = ay_reg;
  assign dsp_az       = az_reg;
  assign dsp_carry_in = 1'b0;
  assign dsp_multiply = ctrl_tag.vld & ctrl_tag.first;
  assign dsp_accum    = ~dsp_multiply;

  dsp_result_fifo #(
    .WIDTH(DWIDTH + LEN_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (cap_vld_pipe[CTRL_TO_RESULT-1]),
    .push_data({dsp_result, cap_len_pipe[CTRL_TO_RESULT-1]}),
    .pop      (s.out_ready),
    .valid    (fifo_valid),
    .pop_data (fifo_data)
  );

  assign s.in_ready  = in_ready;
  assign s.out_valid = fifo_valid;
  assign s.out_data  = fifo_data[DWIDTH+LEN_W-1 -: DWIDTH];
  assign s.out_len   = fifo_data[LEN_W-1:0];
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer driving a dsp_slice: vector table plus reset/backpressure sequences.
module tb_dsp_mac_sequencer;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int FD = 4;

  typedef struct {
    int            n;
    int            gap;
    logic [DW-1:0] a [4];
    logic [DW-1:0] b [4];
    logic [DW-1:0] exp_data;
    logic [LW-1:0] exp_len;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [LW-1:0] len;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          dsp_reset, dsp_carry_in, dsp_multiply, dsp_accum, dsp_carry_out;
  logic [DW-1:0] dsp_ax, dsp_ay, dsp_az, dsp_result;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   k_acc;
  exp_t sb [$];
  exp_t mon_e;
  vec_t vt [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_sequencer_if #(.DWIDTH(DW), .LEN_W(LW)) bus ();

  dsp_mac_sequencer #(.DWIDTH(DW), .LEN_W(LW), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s           (bus),
    .dsp_reset   (dsp_reset),
    .dsp_ax      (dsp_ax),
    .dsp_ay      (dsp_ay),
    .dsp_az      (dsp_az),
    .dsp_carry_in(dsp_carry_in),
    .dsp_multiply(dsp_multiply),
    .dsp_accum   (dsp_accum),
    .dsp_result  (dsp_result)
  );

  dsp_slice #(.DWIDTH(DW)) slice (
    .clk      (clk),
    .reset    (dsp_reset),
    .ax       (dsp_ax),
    .ay       (dsp_ay),
    .az       (dsp_az),
    .carry_in (dsp_carry_in),
    .multiply (dsp_multiply),
    .accum    (dsp_accum),
    .result   (dsp_result),
    .carry_out(dsp_carry_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [LW-1:0] l);
    exp_t e;
    e.data = d;
    e.len  = l;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!bus.in_ready && k < 100) begin
      step();
      k++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got in_ready=0 after 100 cycles, expected 1", name);
    end
  endtask

  // Operand bytes are packed element 0 in the low byte
  task automatic set_vec(input int idx, input int n, input int gap, input logic [31:0] av,
                         input logic [31:0] bv, input logic [7:0] ed, input logic [7:0] el);
    vt[idx].n        = n;
    vt[idx].gap      = gap;
    vt[idx].exp_data = ed;
    vt[idx].exp_len  = el;
    for (int i = 0; i < 4; i++) begin
      vt[idx].a[i] = av[8*i +: 8];
      vt[idx].b[i] = bv[8*i +: 8];
    end
  endtask

  task automatic send_elem(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last,
                           input logic expect_out, input logic [DW-1:0] ed, input logic [LW-1:0] el);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    wait_ready("in_ready_elem");
    if (expect_out) begin
      push_exp(ed, el);
      last_acc_cyc = cyc;
    end
    step();
    idle_inputs();
  endtask

  task automatic send_vec(input int idx);
    for (int i = 0; i < vt[idx].n; i++) begin
      send_elem(vt[idx].a[i], vt[idx].b[i], i == vt[idx].n - 1, i == vt[idx].n - 1,
                vt[idx].exp_data, vt[idx].exp_len);
      repeat (vt[idx].gap) step();
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      step();
      k++;
    end
    check(name, sb.size(), 0);
    repeat (8) step();
  endtask

  task automatic flush_checks(input string tag);
    step();
    check({tag, "_flush1_dsp_reset"}, dsp_reset, 1);
    check({tag, "_flush1_in_ready"}, bus.in_ready, 0);
    step();
    check({tag, "_flush2_dsp_reset"}, dsp_reset, 1);
    check({tag, "_flush2_in_ready"}, bus.in_ready, 0);
    step();
    check({tag, "_run_dsp_reset"}, dsp_reset, 0);
    check({tag, "_run_in_ready"}, bus.in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got data=0x%0h len=%0d, expected no output", bus.out_data, bus.out_len);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", bus.out_data, mon_e.data);
        check("out_len", bus.out_len, mon_e.len);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    bus.out_ready = 1'b0;
    resetn = 1'b0;

    set_vec(0, 3, 0, 32'h00030201, 32'h00060504, 8'h20, 8'd3);
    set_vec(1, 3, 2, 32'h00030201, 32'h00060504, 8'h20, 8'd3);
    set_vec(2, 1, 0, 32'h00000002, 32'h00000003, 8'h06, 8'd1);
    set_vec(3, 2, 0, 32'h000001FC, 32'h00000705, 8'hF3, 8'd2);
    set_vec(4, 2, 0, 32'h00006464, 32'h00006464, 8'hFE, 8'd2);
    set_vec(5, 2, 1, 32'h0000FF80, 32'h0000017F, 8'h7F, 8'd2);
    set_vec(6, 1, 0, 32'h00000080, 32'h00000080, 8'h7F, 8'd1);
    set_vec(7, 4, 0, 32'h00000000, 32'h09090909, 8'h00, 8'd4);

    repeat (3) step();
    check("rst_dsp_reset", dsp_reset, 1);
    check("rst_dsp_accum", dsp_accum, 1);
    check("rst_dsp_multiply", dsp_multiply, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_dsp_ay", dsp_ay, 0);
    check("rst_carry_in", dsp_carry_in, 0);

    resetn = 1'b1;
    flush_checks("init");
    check("idle_multiply", dsp_multiply, 0);
    check("idle_accum", dsp_accum, 1);

    bus.out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      send_vec(v);
      if (v == 0) begin
        while (!bus.out_valid && (cyc - last_acc_cyc) < 20) step();
        check("latency_last_to_out_valid", cyc - last_acc_cyc, 4);
      end
    end
    drain("table_drain");

    // Backpressure: six single-element vectors against a stalled consumer
    bus.out_ready = 1'b0;
    k_acc = 0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_b     = 8'd3;
    bus.in_a     = 8'(k_acc + 1);
    for (int c = 0; c < 30 && k_acc < 6; c++) begin
      if (bus.in_ready) begin
        push_exp(8'((k_acc + 1) * 3), 8'd1);
        k_acc++;
      end
      step();
      bus.in_a = 8'(k_acc + 1);
    end
    check("accepted_while_stalled", k_acc, 4);
    check("in_ready_when_full", bus.in_ready, 0);
    check("out_valid_when_full", bus.out_valid, 1);
    check("held_out_data", bus.out_data, 3);
    step();
    check("held_out_data_stable", bus.out_data, 3);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && k_acc < 6; c++) begin
      if (bus.in_ready) begin
        push_exp(8'((k_acc + 1) * 3), 8'd1);
        k_acc++;
      end
      step();
      bus.in_a = 8'(k_acc + 1);
    end
    idle_inputs();
    check("accepted_after_release", k_acc, 6);
    drain("backpressure_drain");

    // Reset mid-vector with a completed result parked in the FIFO
    bus.out_ready = 1'b0;
    send_elem(8'd9, 8'd1, 1'b1, 1'b1, 8'd9, 8'd1);
    send_elem(8'd7, 8'd7, 1'b0, 1'b0, 8'd0, 8'd0);
    send_elem(8'd7, 8'd7, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int c = 0; c < 10 && !bus.out_valid; c++) step();
    check("pre_reset_out_valid", bus.out_valid, 1);
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_dsp_reset", dsp_reset, 1);
    check("midrst_dsp_accum", dsp_accum, 1);
    check("midrst_dsp_multiply", dsp_multiply, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_dsp_ay", dsp_ay, 0);
    sb.delete();
    step();
    step();
    resetn = 1'b1;
    flush_checks("midrst");
    check("post_reset_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    send_elem(8'd7, 8'hFE, 1'b1, 1'b1, 8'hF2, 8'd1);
    drain("post_reset_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
